// File: rtl/sample_issuer_pkg.sv
// Shared types and default sizing for the sample issuer.
package sample_issuer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } issuer_state_t;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_FIFO_DEPTH = 4;
    localparam int DEFAULT_BATCH_SIZE = 1000;
    localparam int DEFAULT_CNT_BITS   = 10;

endpackage

// File: rtl/sample_fifo.sv
// Small sample FIFO. The head entry is held in a register (rd_data) so the
// downstream datapath sees a glitch-free value; a write into an empty FIFO
// appears on rd_data after the writing edge, never in the same cycle.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sample_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  full
);

    localparam int              PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]  TWO_C   = (PTR_W + 1)'(2);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]        count_q, count_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic                  push, pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_C);
    assign rd_data = head_q;

    assign pop  = rd_en && !empty;
    assign push = wr_en && (!full || pop);

    // Next occupancy and next head value, including a same-cycle write.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (count_d == '0) begin
            head_d = '0;
        end else if (pop) begin
            head_d = (count_q >= TWO_C) ? mem_q[rd_ptr_q + 1'b1] : wr_data;
        end else if (count_q == '0) begin
            head_d = wr_data;
        end
    end

    // Pointer, occupancy and head register update.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    // Storage array; contents are only observed through the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/sample_issuer.sv
// Issues host-written samples to the filter datapath one at a time over a
// valid/ready handshake and flags completion after BATCH_SIZE transfers.
//
// Handshake: a transfer happens on a rising edge where dp_valid && dp_ready;
// once dp_valid is high, dp_data holds until that transfer occurs.
module sample_issuer
    import sample_issuer_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int BATCH_SIZE = DEFAULT_BATCH_SIZE,
    parameter int CNT_BITS   = DEFAULT_CNT_BITS
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  host_wr,
    input  logic [DATA_WIDTH-1:0] host_data,
    output logic                  fifo_full,
    input  logic                  dp_ready,
    output logic                  dp_valid,
    output logic [DATA_WIDTH-1:0] dp_data,
    output logic [CNT_BITS-1:0]   issued_count,
    output logic                  batch_done,
    output logic                  busy,
    output logic                  overrun_err,
    output issuer_state_t         state_dbg
);

    localparam logic [CNT_BITS-1:0] LAST_C  = CNT_BITS'(BATCH_SIZE - 1);
    localparam logic [CNT_BITS-1:0] BATCH_C = CNT_BITS'(BATCH_SIZE);

    issuer_state_t       state_q;
    logic [CNT_BITS-1:0] count_q;
    logic                batch_done_q;
    logic                overrun_q;
    logic                fifo_empty;
    logic                xfer;

    assign dp_valid     = (state_q == ISSUE) && !fifo_empty;
    assign xfer         = dp_valid && dp_ready;
    assign busy         = (state_q == ISSUE);
    assign issued_count = count_q;
    assign batch_done   = batch_done_q;
    assign overrun_err  = overrun_q;
    assign state_dbg    = state_q;

    // clear discards any same-cycle write and transfer.
    sample_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .n_rst   (n_rst),
        .flush   (clear),
        .wr_en   (host_wr && !clear),
        .wr_data (host_data),
        .rd_en   (xfer && !clear),
        .rd_data (dp_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Batch FSM with issued-sample counter, completion pulse and sticky overrun flag.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            batch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else if (clear) begin
            state_q      <= IDLE;
            count_q      <= '0;
            batch_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            if (host_wr && fifo_full && !xfer) overrun_q <= 1'b1;
            batch_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ISSUE;
                        count_q <= '0;
                    end
                end
                ISSUE: begin
                    if (xfer) begin
                        if (count_q == LAST_C) begin
                            state_q      <= DONE;
                            count_q      <= BATCH_C;
                            batch_done_q <= 1'b1;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_issuer.sv
// Directed bench for sample_issuer: a vector table for the preload, overrun
// and full write+pop cases, plus hand sequences for a full batch, clear
// mid-batch and asynchronous reset mid-batch.
module tb_sample_issuer;
    import sample_issuer_pkg::*;

    logic          clk;
    logic          n_rst;
    logic          clear;
    logic          start;
    logic          host_wr;
    logic [15:0]   host_data;
    logic          fifo_full;
    logic          dp_ready;
    logic          dp_valid;
    logic [15:0]   dp_data;
    logic [9:0]    issued_count;
    logic          batch_done;
    logic          busy;
    logic          overrun_err;
    issuer_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_q[$];

    typedef struct {
        logic        clr;
        logic        st;
        logic        wr;
        logic [15:0] wdata;
        logic        rdy;
        logic        e_full;
        logic        e_valid;
        logic [15:0] e_data;
        logic [9:0]  e_cnt;
        logic        e_bd;
        logic        e_busy;
        logic        e_ov;
    } vec_t;

    vec_t vq[$];

    sample_issuer dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .start        (start),
        .host_wr      (host_wr),
        .host_data    (host_data),
        .fifo_full    (fifo_full),
        .dp_ready     (dp_ready),
        .dp_valid     (dp_valid),
        .dp_data      (dp_data),
        .issued_count (issued_count),
        .batch_done   (batch_done),
        .busy         (busy),
        .overrun_err  (overrun_err),
        .state_dbg    (state_dbg)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear     = 1'b0;
        start     = 1'b0;
        host_wr   = 1'b0;
        host_data = 16'h0000;
        dp_ready  = 1'b0;
    endtask

    task automatic add_vec(input logic clr, input logic st, input logic wr, input logic [15:0] wdata,
                           input logic rdy, input logic e_full, input logic e_valid, input logic [15:0] e_data,
                           input logic [9:0] e_cnt, input logic e_bd, input logic e_busy, input logic e_ov);
        vec_t v;
        v.clr = clr; v.st = st; v.wr = wr; v.wdata = wdata; v.rdy = rdy;
        v.e_full = e_full; v.e_valid = e_valid; v.e_data = e_data; v.e_cnt = e_cnt;
        v.e_bd = e_bd; v.e_busy = e_busy; v.e_ov = e_ov;
        vq.push_back(v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(state_dbg), 32'(IDLE));
        check({tag, "_cnt"}, 32'(issued_count), 32'd0);
        check({tag, "_bd"}, 32'(batch_done), 32'd0);
        check({tag, "_ov"}, 32'(overrun_err), 32'd0);
        check({tag, "_valid"}, 32'(dp_valid), 32'd0);
        check({tag, "_data"}, 32'(dp_data), 32'd0);
        check({tag, "_full"}, 32'(fifo_full), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // Start a batch and stream with dp_ready=1 until issued_count hits target.
    task automatic run_to_count(input int target, input string tag);
        int cyc;
        int wr_i;
        cyc  = 0;
        wr_i = 0;
        idle_inputs();
        start = 1'b1;
        step();
        start = 1'b0;
        while (32'(issued_count) != target && cyc < 5000) begin
            dp_ready  = 1'b1;
            host_wr   = !fifo_full;
            host_data = 16'(wr_i) + 16'h4000;
            if (host_wr) wr_i++;
            step();
            cyc++;
        end
        check({tag, "_reach_count"}, 32'(issued_count), 32'(target));
    endtask

    initial begin
        int wr_i;
        int xfers;
        int bd_seen;
        int cyc;
        logic [15:0] exp_d;

        n_rst = 1'b0;
        idle_inputs();
        #3;
        check_reset_values("reset");
        #20;
        n_rst = 1'b1;

        // clr st wr data rdy | full valid data cnt bd busy ov
        add_vec(0,0,1,16'h0011,0, 0,0,16'h0011,10'd0,0,0,0);
        add_vec(0,0,1,16'h0022,0, 0,0,16'h0011,10'd0,0,0,0);
        add_vec(0,0,1,16'h0033,0, 0,0,16'h0011,10'd0,0,0,0);
        add_vec(0,1,0,16'h0000,1, 0,1,16'h0011,10'd0,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,1,16'h0022,10'd1,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,1,16'h0033,10'd2,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,0,16'h0000,10'd3,0,1,0);
        add_vec(0,0,0,16'h0000,0, 0,0,16'h0000,10'd3,0,1,0);
        add_vec(0,0,1,16'hA001,0, 0,1,16'hA001,10'd3,0,1,0);
        add_vec(0,0,1,16'hA002,0, 0,1,16'hA001,10'd3,0,1,0);
        add_vec(0,0,1,16'hA003,0, 0,1,16'hA001,10'd3,0,1,0);
        add_vec(0,0,1,16'hA004,0, 1,1,16'hA001,10'd3,0,1,0);
        add_vec(0,0,1,16'hA005,0, 1,1,16'hA001,10'd3,0,1,1);
        add_vec(0,0,0,16'h0000,0, 1,1,16'hA001,10'd3,0,1,1);
        add_vec(1,0,0,16'h0000,0, 0,0,16'h0000,10'd0,0,0,0);
        add_vec(0,0,1,16'hB001,0, 0,0,16'hB001,10'd0,0,0,0);
        add_vec(0,0,1,16'hB002,0, 0,0,16'hB001,10'd0,0,0,0);
        add_vec(0,0,1,16'hB003,0, 0,0,16'hB001,10'd0,0,0,0);
        add_vec(0,0,1,16'hB004,0, 1,0,16'hB001,10'd0,0,0,0);
        add_vec(0,1,0,16'h0000,1, 1,1,16'hB001,10'd0,0,1,0);
        add_vec(0,0,1,16'hB005,1, 1,1,16'hB002,10'd1,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,1,16'hB003,10'd2,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,1,16'hB004,10'd3,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,1,16'hB005,10'd4,0,1,0);
        add_vec(0,0,0,16'h0000,1, 0,0,16'h0000,10'd5,0,1,0);
        add_vec(1,0,0,16'h0000,0, 0,0,16'h0000,10'd0,0,0,0);

        for (int i = 0; i < vq.size(); i++) begin
            clear     = vq[i].clr;
            start     = vq[i].st;
            host_wr   = vq[i].wr;
            host_data = vq[i].wdata;
            dp_ready  = vq[i].rdy;
            step();
            check($sformatf("vec%0d_full", i),  32'(fifo_full),    32'(vq[i].e_full));
            check($sformatf("vec%0d_valid", i), 32'(dp_valid),     32'(vq[i].e_valid));
            check($sformatf("vec%0d_data", i),  32'(dp_data),      32'(vq[i].e_data));
            check($sformatf("vec%0d_cnt", i),   32'(issued_count), 32'(vq[i].e_cnt));
            check($sformatf("vec%0d_bd", i),    32'(batch_done),   32'(vq[i].e_bd));
            check($sformatf("vec%0d_busy", i),  32'(busy),         32'(vq[i].e_busy));
            check($sformatf("vec%0d_ov", i),    32'(overrun_err),  32'(vq[i].e_ov));
        end
        idle_inputs();

        // Full batch with random dp_ready; every transfer must match write order.
        exp_q.delete();
        wr_i = 0; xfers = 0; bd_seen = 0; cyc = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        while (bd_seen == 0 && cyc < 20000) begin
            host_wr = (wr_i < 1000) && !fifo_full;
            if (host_wr) begin
                host_data = 16'(wr_i) ^ 16'h5A5A;
                exp_q.push_back(host_data);
                wr_i++;
            end
            dp_ready = 1'($urandom_range(0, 1));
            if (dp_valid && dp_ready) begin
                exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
                check("batch_data", 32'(dp_data), 32'(exp_d));
                xfers++;
            end
            step();
            cyc++;
            if (batch_done) begin
                bd_seen++;
                check("batch_done_cnt", 32'(issued_count), 32'd1000);
                check("batch_done_state", 32'(state_dbg), 32'(DONE));
                check("batch_xfers", 32'(xfers), 32'd1000);
            end
        end
        check("batch_done_seen", 32'(bd_seen), 32'd1);
        idle_inputs();
        step();
        check("batch_after_bd", 32'(batch_done), 32'd0);
        check("batch_after_state", 32'(state_dbg), 32'(IDLE));
        check("batch_after_cnt", 32'(issued_count), 32'd1000);
        check("batch_after_busy", 32'(busy), 32'd0);
        check("batch_left", 32'(exp_q.size()), 32'd0);
        step();
        check("batch_hold_cnt", 32'(issued_count), 32'd1000);

        // Clear mid-batch with start and host_wr in the same cycle.
        run_to_count(500, "clr");
        clear     = 1'b1;
        start     = 1'b1;
        host_wr   = 1'b1;
        host_data = 16'hDEAD;
        dp_ready  = 1'b1;
        step();
        idle_inputs();
        check_reset_values("clr");
        step();
        check("clr_fifo_empty", 32'(dp_data), 32'd0);
        check("clr_no_bd", 32'(batch_done), 32'd0);
        check("clr_state_idle", 32'(state_dbg), 32'(IDLE));

        // Asynchronous reset between edges mid-batch.
        run_to_count(10, "arst");
        idle_inputs();
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_values("arst");
        #2;
        n_rst = 1'b1;
        step();
        check_reset_values("arst_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
